// File: rtl/strided_address_generator.sv
// strided_address_generator
// Two-level (inner/outer loop) strided address generator. After `start` it
// streams base + outer*outer_stride + inner*inner_stride over a valid/ready
// handshake, inner index fastest, then pulses `done`.
// Optional feature: define ADDR_GEN_BOUNDS_CHECK_EN to stop on any address
// at or beyond CELL_COUNT and raise a sticky `err` instead of wrapping.
module strided_address_generator #(
    parameter int CELL_COUNT  = 2048,
    parameter int MAX_INNER   = 16,
    parameter int MAX_OUTER   = 16,
    parameter int ADDR_WIDTH  = $clog2(CELL_COUNT),
    parameter int INNER_WIDTH = $clog2(MAX_INNER),
    parameter int OUTER_WIDTH = $clog2(MAX_OUTER)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [INNER_WIDTH-1:0] inner_last,
    input  logic [OUTER_WIDTH-1:0] outer_last,
    input  logic [ADDR_WIDTH-1:0]  inner_stride,
    input  logic [ADDR_WIDTH-1:0]  outer_stride,
    input  logic                   addr_ready,
    output logic                   addr_valid,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic [INNER_WIDTH-1:0] inner_idx,
    output logic [OUTER_WIDTH-1:0] outer_idx,
    output logic                   last_inner,
    output logic                   last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0]  row_base_reg, row_base_next;
    logic [INNER_WIDTH-1:0] inner_idx_reg, inner_idx_next;
    logic [OUTER_WIDTH-1:0] outer_idx_reg, outer_idx_next;
    logic [INNER_WIDTH-1:0] inner_last_reg, inner_last_next;
    logic [OUTER_WIDTH-1:0] outer_last_reg, outer_last_next;
    logic [ADDR_WIDTH-1:0]  inner_stride_reg, inner_stride_next;
    logic [ADDR_WIDTH-1:0]  outer_stride_reg, outer_stride_next;
    logic                   err_reg, err_next;

    // Candidate next addresses and their out-of-range flags.
    logic [ADDR_WIDTH-1:0]  inner_addr;
    logic [ADDR_WIDTH-1:0]  outer_addr;
    logic                   inner_ovf;
    logic                   outer_ovf;
    logic                   base_ovf;

`ifdef ADDR_GEN_BOUNDS_CHECK_EN
    // Sums carry one extra bit so an overflow past 2^ADDR_WIDTH is still seen.
    localparam logic [ADDR_WIDTH:0] CELL_LIMIT = (ADDR_WIDTH+1)'(CELL_COUNT);
    logic [ADDR_WIDTH:0] inner_sum;
    logic [ADDR_WIDTH:0] outer_sum;

    assign inner_sum  = {1'b0, addr_reg} + {1'b0, inner_stride_reg};
    assign outer_sum  = {1'b0, row_base_reg} + {1'b0, outer_stride_reg};
    assign inner_addr = inner_sum[ADDR_WIDTH-1:0];
    assign outer_addr = outer_sum[ADDR_WIDTH-1:0];
    assign inner_ovf  = (inner_sum >= CELL_LIMIT);
    assign outer_ovf  = (outer_sum >= CELL_LIMIT);
    assign base_ovf   = ({1'b0, base_addr} >= CELL_LIMIT);
`else
    // Plain modulo 2^ADDR_WIDTH arithmetic; err can never be set.
    assign inner_addr = addr_reg + inner_stride_reg;
    assign outer_addr = row_base_reg + outer_stride_reg;
    assign inner_ovf  = 1'b0;
    assign outer_ovf  = 1'b0;
    assign base_ovf   = 1'b0;
`endif

    // Next-state and datapath update: start latches config, handshakes walk the pattern.
    always_comb begin
        state_next        = state_reg;
        addr_next         = addr_reg;
        row_base_next     = row_base_reg;
        inner_idx_next    = inner_idx_reg;
        outer_idx_next    = outer_idx_reg;
        inner_last_next   = inner_last_reg;
        outer_last_next   = outer_last_reg;
        inner_stride_next = inner_stride_reg;
        outer_stride_next = outer_stride_reg;
        err_next          = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    inner_last_next   = inner_last;
                    outer_last_next   = outer_last;
                    inner_stride_next = inner_stride;
                    outer_stride_next = outer_stride;
                    addr_next         = base_addr;
                    row_base_next     = base_addr;
                    inner_idx_next    = '0;
                    outer_idx_next    = '0;
                    if (base_ovf) begin
                        // Out-of-range base is never presented.
                        err_next   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        err_next   = 1'b0;
                        state_next = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (addr_ready) begin
                    if (inner_idx_reg < inner_last_reg) begin
                        if (inner_ovf) begin
                            err_next   = 1'b1;
                            state_next = ST_DONE;
                        end else begin
                            addr_next      = inner_addr;
                            inner_idx_next = inner_idx_reg + INNER_WIDTH'(1);
                        end
                    end else if (outer_idx_reg < outer_last_reg) begin
                        if (outer_ovf) begin
                            err_next   = 1'b1;
                            state_next = ST_DONE;
                        end else begin
                            addr_next      = outer_addr;
                            row_base_next  = outer_addr;
                            inner_idx_next = '0;
                            outer_idx_next = outer_idx_reg + OUTER_WIDTH'(1);
                        end
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; the active-low reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            addr_reg         <= '0;
            row_base_reg     <= '0;
            inner_idx_reg    <= '0;
            outer_idx_reg    <= '0;
            inner_last_reg   <= '0;
            outer_last_reg   <= '0;
            inner_stride_reg <= '0;
            outer_stride_reg <= '0;
            err_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            addr_reg         <= addr_next;
            row_base_reg     <= row_base_next;
            inner_idx_reg    <= inner_idx_next;
            outer_idx_reg    <= outer_idx_next;
            inner_last_reg   <= inner_last_next;
            outer_last_reg   <= outer_last_next;
            inner_stride_reg <= inner_stride_next;
            outer_stride_reg <= outer_stride_next;
            err_reg          <= err_next;
        end
    end

    // Outputs decode registers only; nothing combinational from addr_ready or start.
    assign addr_valid = (state_reg == ST_RUN);
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign addr       = addr_reg;
    assign inner_idx  = inner_idx_reg;
    assign outer_idx  = outer_idx_reg;
    assign last_inner = addr_valid && (inner_idx_reg == inner_last_reg);
    assign last       = last_inner && (outer_idx_reg == outer_last_reg);
    assign err        = err_reg;

endmodule

// File: doc/strided_address_generator.md
# strided_address_generator

Two-level (inner/outer loop) strided address generator for the on-chip cell memories; the next generation of the single-offset base+offset generator. It takes a base address, two strides and two loop bounds, then streams one address per accepted handshake until the whole 2-D pattern is done. It sits between the layer controller, which issues `start` and the configuration, and a memory port or read/write scheduler, which consumes `addr` via valid/ready.

## Interface
Parameters:
- `CELL_COUNT`, 2048, number of addressable cells in the target memory.
- `MAX_INNER`, 16, maximum inner-loop length.
- `MAX_OUTER`, 16, maximum outer-loop length.
- `ADDR_WIDTH`, `$clog2(CELL_COUNT)`, address and stride width.
- `INNER_WIDTH`, `$clog2(MAX_INNER)`, inner index width.
- `OUTER_WIDTH`, `$clog2(MAX_OUTER)`, outer index width.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a pattern; honoured only in IDLE.
- `abort`  in  1  synchronous cancel of the pattern in progress.
- `base_addr`  in  ADDR_WIDTH  first address of the pattern.
- `inner_last`  in  INNER_WIDTH  last inner index; inner length is `inner_last+1`.
- `outer_last`  in  OUTER_WIDTH  last outer index; outer length is `outer_last+1`.
- `inner_stride`  in  ADDR_WIDTH  step between consecutive inner addresses.
- `outer_stride`  in  ADDR_WIDTH  step between consecutive row bases.
- `addr_ready`  in  1  consumer accepts `addr` this cycle.
- `addr_valid`  out  1  `addr` is valid.
- `addr`  out  ADDR_WIDTH  current address.
- `inner_idx`  out  INNER_WIDTH  inner index of the current `addr`.
- `outer_idx`  out  OUTER_WIDTH  outer index of the current `addr`.
- `last_inner`  out  1  current `addr` ends a row.
- `last`  out  1  current `addr` is the final address of the pattern.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the final handshake.
- `err`  out  1  sticky bounds error; tied 0 unless the macro is defined.

## Operation
- The FSM has three states: IDLE, RUN and DONE. In IDLE, `start` does all of the following:
  - latches the strides and bounds;
  - sets `row_base` and `addr` to `base_addr`;
  - zeroes both indices, clears `err` and enters RUN.
- In RUN, `addr_valid`=1. A handshake (`addr_valid & addr_ready`) advances the pattern as follows:
  - if `inner_idx < inner_last`, then `inner_idx++` and `addr += inner_stride`;
  - else if `outer_idx < outer_last`, then `inner_idx`=0, `outer_idx++`, `row_base += outer_stride` and `addr = row_base + outer_stride`;
  - otherwise the FSM enters DONE.
- Without a handshake, `addr`, the indices and the flags hold.
- DONE asserts `done` for one cycle, then the FSM returns to IDLE.
- `last_inner` = (`inner_idx == inner_last`). `last` = `last_inner & (outer_idx == outer_last)`. Both are qualified by `addr_valid`.
- Total handshakes per pattern = `(inner_last+1)*(outer_last+1)`. `inner_last`=`outer_last`=0 gives a single address with `last`=1.
- `start` outside IDLE is ignored. Input changes after `start` have no effect until the next `start`.
- `abort` in RUN or DONE sends the FSM to IDLE on the next edge. `addr_valid` drops and no `done` pulse follows. `abort` has priority over a simultaneous handshake.
- Arithmetic is unsigned, modulo 2^ADDR_WIDTH (carry discarded), unless the macro below is defined.
- Asserting `rst` mid-pattern clears the block immediately, and no `done` is issued.

## Timing
- Reset values: state IDLE; `addr_valid`, `addr`, `inner_idx`, `outer_idx`, `last_inner`, `last`, `busy`, `done` and `err` all 0.
- All outputs are registered or decoded from registers only; there is no combinational path from `addr_ready` or `start` to any output.
- Latency from `start` to the first `addr_valid` is 1 cycle; `busy` rises in the same cycle.
- Throughput is one address per cycle while `addr_ready`=1.
- `done` pulses the cycle after the final handshake. `busy` falls the cycle after `done`, and a new `start` is accepted from that cycle on.

## Configuration
- `ADDR_GEN_BOUNDS_CHECK_EN` defined:
  - next addresses are computed at ADDR_WIDTH+1 bits;
  - a next address ≥ `CELL_COUNT`, or a `base_addr` ≥ `CELL_COUNT` at `start`, is never presented;
  - instead `err` sets (sticky until the next `start`) and the FSM goes to DONE, so `done` still pulses.
- `ADDR_GEN_BOUNDS_CHECK_EN` undefined: addresses wrap modulo 2^ADDR_WIDTH and `err` is constant 0.

## Test plan
- Basic pattern, `addr_ready`=1: base 100, `inner_last` 2, `inner_stride` 1, `outer_last` 1, `outer_stride` 16 → `addr` 100,101,102,116,117,118 on consecutive cycles. `last_inner` is 1 on 102 and 118, `last` on 118, and `done` pulses one cycle after 118.
- Backpressure: same pattern with `addr_ready` low for 3 cycles at `addr`=101 → `addr` holds 101, nothing is skipped or duplicated, and 6 handshakes total.
- Abort: assert `abort` after 2 handshakes → `addr_valid`=0 and `busy`=0 next cycle, no `done`. A following `start` restarts at the new `base_addr`.
- Wrap/bounds: `CELL_COUNT` 2048, base 2046, stride 1, `inner_last` 3, `outer_last` 0:
  - macro off → 2046, 2047, 0, 1;
  - macro on → 2046, 2047, then `err`=1 and `done` pulses.
- Degenerate and ignored `start`: `inner_last`=`outer_last`=0, base 5 → a single `addr` 5 with `last`=1. A `start` pulsed while `busy` is ignored.
- Reset mid-run: drive `rst` low during RUN → all outputs are 0 before the next edge, and the FSM stays IDLE after release until `start`.
